// File: rtl/ss_pkg.sv
// Shared types for the segment write scheduler.
// seg_t is sized for the widest supported index; narrower ones zero-extend.
package ss_pkg;

    localparam int N_REQ  = 2;
    localparam int SEG_AW = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        START,
        SETTLE,
        RUN,
        ACK
    } state_t;

    typedef struct packed {
        logic [SEG_AW-1:0] si;
        logic [SEG_AW-1:0] ei;
    } seg_t;

endpackage

// File: rtl/ss_write_sched_arb.sv
// Two-way round-robin arbiter; owns the priority pointer.
// The pointer moves to the requester opposite the one just served.
module ss_rr_arb
    import ss_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             adv,
    input  logic             cur,
    output logic [N_REQ-1:0] gnt
);

    logic ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~cur;
        end
    end

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (req[~ptr]) begin
                gnt[~ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ss_write_sched.sv
// Shares one segment write engine between two requesters.
// Engine controls and acks are registered off the current state.
module ss_write_sched
    import ss_pkg::*;
#(
    parameter int SIZE_ADDR  = 6,
    parameter int SIZE_DATA  = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [1:0]             i_req,
    input  logic [2*SIZE_ADDR-1:0] i_si,
    input  logic [2*SIZE_ADDR-1:0] i_ei,
    input  logic [2*SIZE_DATA-1:0] i_data,
    output logic [1:0]             o_ack,
    output logic                   o_err,
    output logic [1:0]             o_gnt,
    output logic                   o_start_write_data,
    output logic                   o_en_write_data,
    output logic [SIZE_ADDR-1:0]   o_si_ram,
    output logic [SIZE_ADDR-1:0]   o_ei_ram,
    output logic [SIZE_DATA-1:0]   o_data_ram,
    input  logic                   i_done_write_data,
    output logic                   o_busy
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t               state;
    state_t               state_nx;
    seg_t                 seg_q;
    logic [1:0]           arb_gnt;
    logic                 bad_q;
    logic                 bad;
    logic [SCW-1:0]       settle_cnt;
    logic                 settle_last;
    logic                 take;
    logic [SIZE_ADDR-1:0] si_sel;
    logic [SIZE_ADDR-1:0] ei_sel;

    ss_rr_arb u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (i_req),
        .en      (state == IDLE),
        .adv     (state == ACK),
        .cur     (o_gnt[1]),
        .gnt     (arb_gnt)
    );

    assign take        = (state == IDLE) && (|i_req);
    assign bad         = seg_q.si > seg_q.ei;
    assign settle_last = settle_cnt == SCW'(SETTLE_CYC - 1);
    assign o_busy      = state != IDLE;
    assign o_si_ram    = seg_q.si[SIZE_ADDR-1:0];
    assign o_ei_ram    = seg_q.ei[SIZE_ADDR-1:0];

    assign si_sel = arb_gnt[1] ? i_si[2*SIZE_ADDR-1:SIZE_ADDR]
                               : i_si[SIZE_ADDR-1:0];
    assign ei_sel = arb_gnt[1] ? i_ei[2*SIZE_ADDR-1:SIZE_ADDR]
                               : i_ei[SIZE_ADDR-1:0];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (|i_req) state_nx = CHECK;
            CHECK:   state_nx = bad ? ACK : START;
            START:   state_nx = SETTLE;
            SETTLE:  if (settle_last) state_nx = RUN;
            RUN:     if (i_done_write_data) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            o_gnt              <= '0;
            seg_q              <= '0;
            bad_q              <= 1'b0;
            settle_cnt         <= '0;
            o_start_write_data <= 1'b0;
            o_en_write_data    <= 1'b0;
            o_ack              <= '0;
            o_err              <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                o_gnt    <= arb_gnt;
                seg_q.si <= SEG_AW'(si_sel);
                seg_q.ei <= SEG_AW'(ei_sel);
            end else if (state == ACK) begin
                o_gnt <= '0;
            end
            if (state == CHECK) begin
                bad_q <= bad;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            // Done is only meaningful in RUN; earlier it is stale.
            o_start_write_data <= state == START;
            o_en_write_data    <= (state == SETTLE) ||
                                  ((state == RUN) && !i_done_write_data);
            o_ack <= (state == ACK) ? o_gnt : 2'b00;
            o_err <= (state == ACK) && bad_q;
        end
    end

    always_comb begin
        o_data_ram = '0;
        unique case (1'b1)
            o_gnt[0]: o_data_ram = i_data[SIZE_DATA-1:0];
            o_gnt[1]: o_data_ram = i_data[2*SIZE_DATA-1:SIZE_DATA];
            default: ;
        endcase
    end

endmodule
